mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: RV32 memory stage, IDLE/REQ handshake to a word-wide data memory.
// Optional MEM_TIMEOUT_EN: abort a request after 16 unacknowledged cycles.
module mem_stage (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [6:0]  i_op,
    input  logic [2:0]  i_fun3,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_aluout,
    input  logic [31:0] i_store_dat,
    output logic        o_stall,
    output logic [31:0] o_MEM_aludat,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wb_valid,
    output logic        o_wb_we,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_dat,
    output logic        o_misalign,
    output logic        o_bus_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    logic [0:0]  r_state;
    logic [4:0]  r_rd;
    logic [2:0]  r_fun3;
    logic [1:0]  r_lane;
    logic        r_ld;

    logic        w_accept;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_alu;
    logic        w_bad;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_ld_dat;

`ifdef MEM_TIMEOUT_EN
    logic [3:0]  r_cnt;
    logic        r_bus_err;
    assign o_bus_err = r_bus_err;
`else
    assign o_bus_err = 1'b0;
`endif

    assign o_stall  = (r_state == REQ);
    assign w_accept = (r_state == IDLE) && i_valid && (i_op != 7'd0);

    // Classify the incoming opcode; unknown opcodes are dropped silently.
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_is_alu   = 1'b0;
        unique case (1'b1)
            (i_op == OP_LOAD):  w_is_load  = 1'b1;
            (i_op == OP_STORE): w_is_store = 1'b1;
            (i_op == OP_R),
            (i_op == OP_I),
            (i_op == OP_LUI),
            (i_op == OP_AUIPC),
            (i_op == OP_JAL),
            (i_op == OP_JALR):  w_is_alu   = 1'b1;
            default: ;
        endcase
    end

    // Alignment / legal-width check and store byte-lane formation.
    always_comb begin
        w_bad   = 1'b0;
        w_be    = 4'b0000;
        w_wdata = 32'd0;
        if (w_is_load) begin
            case (i_fun3)
                3'd0, 3'd4: w_bad = 1'b0;
                3'd1, 3'd5: w_bad = i_aluout[0];
                3'd2:       w_bad = |i_aluout[1:0];
                default:    w_bad = 1'b1;
            endcase
        end else if (w_is_store) begin
            case (i_fun3)
                3'd0: begin
                    w_be    = 4'b0001 << i_aluout[1:0];
                    w_wdata = {4{i_store_dat[7:0]}};
                end
                3'd1: begin
                    w_bad   = i_aluout[0];
                    w_be    = i_aluout[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{i_store_dat[15:0]}};
                end
                3'd2: begin
                    w_bad   = |i_aluout[1:0];
                    w_be    = 4'b1111;
                    w_wdata = i_store_dat;
                end
                default: w_bad = 1'b1;
            endcase
        end
    end

    assign w_shift = i_dmem_rdata >> {r_lane, 3'b000};

    // Extract and extend the addressed lane of the returned word.
    always_comb begin
        case (r_fun3)
            3'd0:    w_ld_dat = {{24{w_shift[7]}}, w_shift[7:0]};
            3'd4:    w_ld_dat = {24'd0, w_shift[7:0]};
            3'd1:    w_ld_dat = {{16{w_shift[15]}}, w_shift[15:0]};
            3'd5:    w_ld_dat = {16'd0, w_shift[15:0]};
            default: w_ld_dat = i_dmem_rdata;
        endcase
    end

    // Stage FSM, memory request registers and retire/exception pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_rd         <= 5'd0;
            r_fun3       <= 3'd0;
            r_lane       <= 2'd0;
            r_ld         <= 1'b0;
            o_MEM_aludat <= 32'd0;
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= 32'd0;
            o_dmem_wdata <= 32'd0;
            o_dmem_be    <= 4'b0000;
            o_wb_valid   <= 1'b0;
            o_wb_we      <= 1'b0;
            o_wb_rd      <= 5'd0;
            o_wb_dat     <= 32'd0;
            o_misalign   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_cnt        <= 4'd0;
            r_bus_err    <= 1'b0;
`endif
        end else begin
            o_wb_valid <= 1'b0;
            o_wb_we    <= 1'b0;
            o_misalign <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_bus_err  <= 1'b0;
`endif
            if (r_state == IDLE) begin
                if (w_accept) begin
                    o_MEM_aludat <= i_aluout;
                    if (w_is_load || w_is_store) begin
                        if (w_bad) begin
                            o_misalign <= 1'b1;
                        end else begin
                            r_state      <= REQ;
                            r_rd         <= i_rd;
                            r_fun3       <= i_fun3;
                            r_lane       <= i_aluout[1:0];
                            r_ld         <= w_is_load;
                            o_dmem_req   <= 1'b1;
                            o_dmem_we    <= w_is_store;
                            o_dmem_addr  <= {i_aluout[31:2], 2'b00};
                            o_dmem_wdata <= w_wdata;
                            o_dmem_be    <= w_is_store ? w_be : 4'b1111;
`ifdef MEM_TIMEOUT_EN
                            r_cnt        <= 4'd0;
`endif
                        end
                    end else if (w_is_alu) begin
                        o_wb_valid <= 1'b1;
                        o_wb_we    <= (i_rd != 5'd0);
                        o_wb_rd    <= i_rd;
                        o_wb_dat   <= i_aluout;
                    end
                end
            end else if (i_dmem_ack) begin
                r_state    <= IDLE;
                o_dmem_req <= 1'b0;
                o_dmem_we  <= 1'b0;
                o_dmem_be  <= 4'b0000;
                o_wb_valid <= 1'b1;
                o_wb_we    <= r_ld && (r_rd != 5'd0);
                o_wb_rd    <= r_rd;
                o_wb_dat   <= r_ld ? w_ld_dat : o_MEM_aludat;
            end
`ifdef MEM_TIMEOUT_EN
            else if (r_cnt == 4'hF) begin
                r_state    <= IDLE;
                o_dmem_req <= 1'b0;
                o_dmem_we  <= 1'b0;
                o_dmem_be  <= 4'b0000;
                r_bus_err  <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
`endif
        end
    end

endmodule
